// File: rtl/instruction_fetch_unit_if.sv
// Phase, instruction-memory, redirect and IF/ID signals of the fetch stage.
// Defining FETCH_COUNT_EN adds the fetch_count output.
interface instruction_fetch_unit_if;
  logic [4:0]  phasecounter;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halt;
  logic [3:0]  cond_in;
  logic [15:0] pc;
  logic [15:0] command;
  logic [3:0]  cond;
  logic        fetch_valid;
  logic        halted;
`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count;
`endif

  modport master (
    input  phasecounter, imem_data, branch_taken, branch_target, halt, cond_in,
`ifdef FETCH_COUNT_EN
    output fetch_count,
`endif
    output imem_addr, pc, command, cond, fetch_valid, halted
  );

  modport slave (
    output phasecounter, imem_data, branch_taken, branch_target, halt, cond_in,
`ifdef FETCH_COUNT_EN
    input  fetch_count,
`endif
    input  imem_addr, pc, command, cond, fetch_valid, halted
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fetches on the WB phase and absorbs redirects/halt.
// Defining FETCH_COUNT_EN adds a saturating count of performed fetches.
module instruction_fetch_unit (
  input logic                      clock,
  input logic                      reset,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t      state_reg;
  logic [15:0] pc_reg;
  logic [15:0] tgt_reg;
  logic        pend_reg;
  logic [15:0] command_reg;
  logic [3:0]  cond_reg;
  logic        fetch_valid_reg;
  logic        halted_reg;
  logic [15:0] fetch_addr;
  logic        phase_unused;

  // A live redirect beats a remembered one, which beats sequential flow.
  assign fetch_addr = bus.branch_taken ? bus.branch_target :
                      (pend_reg ? tgt_reg : pc_reg);

  // Only the WB bit of the phase vector matters here.
  assign phase_unused = ^bus.phasecounter[3:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= RUN;
      pc_reg          <= 16'h0000;
      tgt_reg         <= 16'h0000;
      pend_reg        <= 1'b0;
      command_reg     <= 16'h0000;
      cond_reg        <= 4'h0;
      fetch_valid_reg <= 1'b0;
      halted_reg      <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (bus.phasecounter[4]) begin
            if (bus.halt) begin
              state_reg       <= HALTED;
              halted_reg      <= 1'b1;
              fetch_valid_reg <= 1'b0;
            end else begin
              command_reg     <= bus.imem_data;
              pc_reg          <= fetch_addr + 16'd1;
              cond_reg        <= bus.cond_in;
              fetch_valid_reg <= 1'b1;
              pend_reg        <= 1'b0;
            end
          end else if (bus.branch_taken) begin
            pend_reg <= 1'b1;
            tgt_reg  <= bus.branch_target;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The pc output always equals the internal program counter.
  assign bus.imem_addr   = fetch_addr;
  assign bus.pc          = pc_reg;
  assign bus.command     = command_reg;
  assign bus.cond        = cond_reg;
  assign bus.fetch_valid = fetch_valid_reg;
  assign bus.halted      = halted_reg;

`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_count_reg <= 16'h0000;
    end else if (bus.phasecounter[4] && (state_reg == RUN) && !bus.halt &&
                 (fetch_count_reg != 16'hFFFF)) begin
      fetch_count_reg <= fetch_count_reg + 16'd1;
    end
  end

  assign bus.fetch_count = fetch_count_reg;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: vector table, hand sequences
// for halt/reset, then random stimulus against a rule-level reference model.
module tb_instruction_fetch_unit;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Instruction memory contents: a few fixed words, a byte-swap hash elsewhere.
  function automatic logic [15:0] imem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1111;
      16'h0001: return 16'h2222;
      16'h0002: return 16'h3333;
      16'h0040: return 16'hABCD;
      default:  return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endcase
  endfunction

  assign bus.imem_data = imem_word(bus.imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: next sequential address, remembered redirect, fetch outputs.
  logic [15:0] m_pc, m_tgt, m_cmd, m_count;
  logic [3:0]  m_cond;
  logic        m_pend, m_valid, m_halted;

  task automatic model_reset();
    m_pc = 16'h0; m_tgt = 16'h0; m_cmd = 16'h0; m_count = 16'h0;
    m_cond = 4'h0; m_pend = 1'b0; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  function automatic logic [15:0] model_addr();
    if (bus.branch_taken) return bus.branch_target;
    if (m_pend) return m_tgt;
    return m_pc;
  endfunction

  task automatic model_edge();
    logic [15:0] a;
    if (m_halted) return;
    if (bus.phasecounter[4]) begin
      if (bus.halt) begin
        m_halted = 1'b1;
        m_valid  = 1'b0;
      end else begin
        a       = model_addr();
        m_cmd   = imem_word(a);
        m_pc    = a + 16'd1;
        m_cond  = bus.cond_in;
        m_valid = 1'b1;
        m_pend  = 1'b0;
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      end
    end else if (bus.branch_taken) begin
      m_pend = 1'b1;
      m_tgt  = bus.branch_target;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".command"},     bus.command,     m_cmd);
    chk({tag, ".pc"},          bus.pc,          m_pc);
    chk({tag, ".cond"},        bus.cond,        m_cond);
    chk({tag, ".fetch_valid"}, bus.fetch_valid, m_valid);
    chk({tag, ".halted"},      bus.halted,      m_halted);
    chk({tag, ".imem_addr"},   bus.imem_addr,   model_addr());
`ifdef FETCH_COUNT_EN
    chk({tag, ".fetch_count"}, bus.fetch_count, m_count);
`endif
  endtask

  task automatic drive(input logic [4:0] ph, input logic bt, input logic [15:0] tgt,
                       input logic h, input logic [3:0] cin);
    bus.phasecounter  = ph;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    bus.halt          = h;
    bus.cond_in       = cin;
  endtask

  task automatic step(input logic [4:0] ph, input logic bt, input logic [15:0] tgt,
                      input logic h, input logic [3:0] cin, input bit do_check);
    drive(ph, bt, tgt, h, cin);
    model_edge();
    @(posedge clock);
    #1;
    if (do_check) check_model("rand");
  endtask

  // Async reset pulse placed mid-cycle, released on the falling edge.
  task automatic reset_pulse(input string tag);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check_model(tag);
    @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [4:0]  phase;
    logic        bt;
    logic [15:0] tgt;
    logic [3:0]  cin;
    logic        chk_addr;
    logic [15:0] exp_addr;
    logic [15:0] exp_cmd;
    logic [15:0] exp_pc;
    logic [3:0]  exp_cond;
    logic        exp_valid;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] t_cmd = 16'h0, t_pc = 16'h0;
  logic [3:0]  t_cond = 4'h0;
  logic        t_valid = 1'b0;

  // One instruction cycle IF..WB with up to two redirect pulses; addr is the
  // hand-derived fetch address expected at the WB edge.
  task automatic add_icycle(input int b1, input logic [15:0] t1, input int b2,
                            input logic [15:0] t2, input logic [3:0] cin,
                            input logic [15:0] addr);
    vec_t v;
    for (int ph = 0; ph < 5; ph++) begin
      v.phase    = 5'(1 << ph);
      v.bt       = (ph == b1) || (ph == b2);
      v.tgt      = (ph == b2) ? t2 : t1;
      v.cin      = (ph == 4) ? cin : ~cin;
      v.chk_addr = (ph == 4);
      v.exp_addr = addr;
      if (ph == 4) begin
        t_cmd   = imem_word(addr);
        t_pc    = addr + 16'd1;
        t_cond  = cin;
        t_valid = 1'b1;
      end
      v.exp_cmd   = t_cmd;
      v.exp_pc    = t_pc;
      v.exp_cond  = t_cond;
      v.exp_valid = t_valid;
      vecs.push_back(v);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          halt_cycles;
    int          ph_idx;
    logic [4:0]  ph;
    logic        bt;
    logic [15:0] tgt;

    add_icycle(-1, 16'h0000, -1, 16'h0000, 4'h1, 16'h0000);
    add_icycle(-1, 16'h0000, -1, 16'h0000, 4'h2, 16'h0001);
    add_icycle(-1, 16'h0000, -1, 16'h0000, 4'h3, 16'h0002);
    add_icycle( 2, 16'h0040, -1, 16'h0000, 4'h4, 16'h0040);
    add_icycle( 4, 16'h0100, -1, 16'h0000, 4'h5, 16'h0100);
    add_icycle( 1, 16'h0200,  3, 16'h0300, 4'h6, 16'h0300);
    add_icycle( 2, 16'hFFFF, -1, 16'h0000, 4'h7, 16'hFFFF);
    add_icycle(-1, 16'h0000, -1, 16'h0000, 4'h8, 16'h0000);

    reset = 1'b0;
    drive(5'h00, 1'b0, 16'h0, 1'b0, 4'h0);
    model_reset();
    @(posedge clock);
    #1;
    chk("reset.command",     bus.command,     16'h0000);
    chk("reset.pc",          bus.pc,          16'h0000);
    chk("reset.cond",        bus.cond,        4'h0);
    chk("reset.fetch_valid", bus.fetch_valid, 1'b0);
    chk("reset.halted",      bus.halted,      1'b0);
    chk("reset.imem_addr",   bus.imem_addr,   16'h0000);
`ifdef FETCH_COUNT_EN
    chk("reset.fetch_count", bus.fetch_count, 16'h0000);
`endif
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].phase, vecs[i].bt, vecs[i].tgt, 1'b0, vecs[i].cin);
      model_edge();
      #1;
      if (vecs[i].chk_addr) chk("tbl.imem_addr", bus.imem_addr, vecs[i].exp_addr);
      @(posedge clock);
      #1;
      chk("tbl.command",     bus.command,     vecs[i].exp_cmd);
      chk("tbl.pc",          bus.pc,          vecs[i].exp_pc);
      chk("tbl.cond",        bus.cond,        vecs[i].exp_cond);
      chk("tbl.fetch_valid", bus.fetch_valid, vecs[i].exp_valid);
      chk("tbl.halted",      bus.halted,      1'b0);
      $display("vec %0d: phase=%b bt=%b cmd=%h pc=%h", i, vecs[i].phase, vecs[i].bt,
               bus.command, bus.pc);
    end

    // Halt with a simultaneous redirect, then ten frozen instruction cycles.
    for (int p = 0; p < 4; p++) step(5'(1 << p), 1'b0, 16'h0, 1'b0, 4'h9, 1'b1);
    step(5'h10, 1'b1, 16'h0500, 1'b1, 4'hA, 1'b1);
    chk("halt.halted",      bus.halted,      1'b1);
    chk("halt.fetch_valid", bus.fetch_valid, 1'b0);
    chk("halt.command",     bus.command,     t_cmd);
    $display("halt: halted=%b cmd=%h pc=%h", bus.halted, bus.command, bus.pc);
    for (int c = 0; c < 50; c++) begin
      bt  = 1'($urandom);
      tgt = 16'($urandom);
      drive(5'(1 << (c % 5)), bt, tgt, 1'($urandom), 4'($urandom));
      model_edge();
      #1;
      chk("frozen.imem_addr", bus.imem_addr, bt ? tgt : t_pc);
      @(posedge clock);
      #1;
      chk("frozen.command",     bus.command,     t_cmd);
      chk("frozen.pc",          bus.pc,          t_pc);
      chk("frozen.cond",        bus.cond,        t_cond);
      chk("frozen.halted",      bus.halted,      1'b1);
      chk("frozen.fetch_valid", bus.fetch_valid, 1'b0);
    end

    // Reset during ID of a new cycle, then fetch resumes from address 0.
    step(5'h01, 1'b0, 16'h0, 1'b0, 4'h0, 1'b1);
    step(5'h02, 1'b0, 16'h0, 1'b0, 4'h0, 1'b1);
    reset_pulse("midrst");
    chk("midrst.halted", bus.halted, 1'b0);
    step(5'h04, 1'b0, 16'h0, 1'b0, 4'h0, 1'b1);
    step(5'h08, 1'b0, 16'h0, 1'b0, 4'h0, 1'b1);
    step(5'h10, 1'b0, 16'h0, 1'b0, 4'hC, 1'b1);
    chk("resume.command", bus.command, 16'h1111);
    chk("resume.pc",      bus.pc,      16'h0001);
    $display("resume: cmd=%h pc=%h", bus.command, bus.pc);

`ifdef FETCH_COUNT_EN
    reset_pulse("cnt_rst");
    for (int c = 0; c < 25; c++) step(5'(1 << (c % 5)), 1'b0, 16'h0, 1'b0, 4'h0, 1'b0);
    chk("count.five", bus.fetch_count, 16'd5);
    $display("count after 5 fetches: %0d", bus.fetch_count);
`endif

    // Random phases (mostly rotating, sometimes zero/multi-hot), redirects, halts.
    halt_cycles = 0;
    ph_idx = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) ph = 5'($urandom);
      else ph = 5'(1 << ph_idx);
      ph_idx = (ph_idx + 1) % 5;
      step(ph, $urandom_range(0, 4) == 0, 16'($urandom), $urandom_range(0, 199) == 0,
           4'($urandom), 1'b1);
      if (m_halted) halt_cycles++;
      if (halt_cycles > 20) begin
        reset_pulse("rand_rst");
        halt_cycles = 0;
      end
    end
    $display("random: %0d cycles done, last cmd=%h pc=%h", 3000, bus.command, bus.pc);

`ifdef FETCH_COUNT_EN
    // Every cycle is a fetch edge here, enough to reach saturation.
    reset_pulse("sat_rst");
    for (int c = 0; c < 65540; c++)
      step(5'h11, 1'b0, 16'h0, 1'b0, 4'($urandom), (c % 8192) == 0);
    chk("sat.fetch_count", bus.fetch_count, 16'hFFFF);
    step(5'h10, 1'b0, 16'h0, 1'b1, 4'h0, 1'b1);
    step(5'h10, 1'b0, 16'h0, 1'b0, 4'h0, 1'b1);
    chk("sat.halted_count", bus.fetch_count, 16'hFFFF);
    $display("saturation: fetch_count=%h", bus.fetch_count);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the five-phase processor: owns the program counter, reads instruction memory and presents `pc`, `command` and `cond` to the IF/ID pipeline register. It updates once per instruction cycle, on the last phase (WB), so its outputs are stable for the whole IF phase, when IF/ID captures them. It also absorbs branch redirects from later stages and a halt request.

## Interface
- Parameters: none.
- `clock`  in  1  single system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low.
- `phasecounter`  in  5  one-hot phase: bit0 IF, bit1 ID, bit2 EX, bit3 MEM, bit4 WB.
- `imem_addr`  out  16  instruction memory address (combinational).
- `imem_data`  in  16  instruction word at `imem_addr` (combinational memory).
- `branch_taken`  in  1  redirect request from the EX/MEM stage.
- `branch_target`  in  16  redirect address, valid with `branch_taken`.
- `halt`  in  1  stop fetching.
- `cond_in`  in  4  condition flags from EX (S,Z,C,V).
- `pc`  out  16  address of the fetched instruction + 1; drives IF/ID `pc`.
- `command`  out  16  fetched instruction; drives IF/ID `command`.
- `cond`  out  4  flags latched with the fetch; drives IF/ID `cond`.
- `fetch_valid`  out  1  1 = `command` is a new, valid fetch.
- `halted`  out  1  1 = in HALTED state.
- `fetch_count`  out  16  number of fetches (only with `FETCH_COUNT_EN`).

## Operation
- Internal registers: `pc_reg[15:0]`, `pend[0]`, `tgt_reg[15:0]`, `state` ∈ {RUN, HALTED}.
- Fetch address is combinational: `branch_taken` ? `branch_target` : `pend` ? `tgt_reg` : `pc_reg`. This value drives `imem_addr`.
- Fetch edge = a rising edge with `phasecounter[4]`=1 and state RUN:
  - If `halt`=1: no fetch. State→HALTED. `fetch_valid`←0. `pc`/`command`/`cond` hold.
  - Otherwise: `command`←`imem_data`. `pc`←addr+1. `pc_reg`←addr+1. `cond`←`cond_in`. `fetch_valid`←1. `pend`←0.
- PC arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000.
- Redirect capture on any edge that is not a fetch edge: if `branch_taken`=1, then `pend`←1 and `tgt_reg`←`branch_target`. A later `branch_taken` overwrites `tgt_reg`.
- Redirect on a fetch edge: the live `branch_taken` is used directly and `pend` is cleared.
- HALTED: exits only on reset.
  - No register updates.
  - `imem_addr` still follows the formula.
  - `branch_taken` is ignored.
  - `halted`=1.
- Only bit4 of `phasecounter` is decoded. Other bits are ignored. An all-zero or multi-hot `phasecounter` causes a fetch exactly when bit4=1.

## Timing
- Reset (async, `reset`=0): `pc`, `command`, `pc_reg`, `tgt_reg` = 16'h0000; `cond`=4'h0; `pend`=0; `fetch_valid`=0; `halted`=0; state RUN; `fetch_count`=0.
- First fetch is at address 16'h0000, at the first WB edge after reset deasserts.
- Latency: the instruction at `imem_addr` during WB appears on `command` in the following IF cycle. The IF/ID register captures it at the end of that IF cycle, i.e. the fetch edge plus one clock.
- Outputs change only on fetch edges or on reset. They are stable through ID/EX/MEM.
- Reset asserted mid-cycle: all state clears immediately. Any pending redirect is lost.
- `branch_taken` together with `halt` on a fetch edge: halt wins, and the redirect is discarded.

## Configuration
- `FETCH_COUNT_EN` defined:
  - Port `fetch_count` exists.
  - It increments by 1 on every fetch edge that performs a fetch.
  - It saturates at 16'hFFFF.
  - It resets to 0.
- `FETCH_COUNT_EN` undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset then run 3 instruction cycles, imem[0..2]=16'h1111,16'h2222,16'h3333 → `command` = 1111/2222/3333 with `pc` = 1/2/3, `fetch_valid`=1 from the first IF cycle.
- `branch_taken`=1, `branch_target`=16'h0040 pulsed during EX; imem[0x40]=16'hABCD → next fetch: `imem_addr`=0x40, `command`=ABCD, `pc`=0x41, `pend` cleared.
- `branch_taken` pulsed on the WB edge itself with target 16'h0100 → same-cycle fetch from 0x100, `pc`=0x101. Then a second pulse in ID to 0x200, overwritten by a third pulse in MEM to 0x300 → fetch from 0x300.
- `pc_reg`=16'hFFFF at fetch → `pc`=16'h0000 and the next fetch is from address 0.
- `halt`=1 on a WB edge, with `branch_taken` in the same cycle → `halted`=1, `fetch_valid`=0, outputs frozen for 10 instruction cycles. Then `reset`=0 mid-ID → all outputs 0 and the next fetch is from address 0.
- With `FETCH_COUNT_EN`: 5 fetches → `fetch_count`=5. Preset near the top and run → it holds at 16'hFFFF. It does not advance while halted.
